// File: rtl/line_feed_control.sv
// Source-side feeder for the 4-line-buffer window generator: forwards the pixel stream under
// per-line credit flow control and appends zero padding lines at end of frame.
module line_feed_control #(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int NUM_LINEBUF = 4,
    parameter int PAD_LINES   = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] o_pixel_data,
    output logic       o_pixel_data_valid,
    input  logic       i_intr,
    output logic       o_frame_done,
    output logic       o_err,
    output logic       o_busy
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int KW = $clog2(NUM_LINEBUF + 1);
    localparam int PW = (PAD_LINES > 1) ? $clog2(PAD_LINES) : 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
    localparam logic [KW-1:0] CREDIT_MAX = KW'(NUM_LINEBUF);
    localparam logic [PW-1:0] PAD_LAST   = PW'((PAD_LINES > 0) ? PAD_LINES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SEND, PAD, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] pad_q, pad_d;
    logic [KW-1:0] credit_q, credit_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic xfer, pad_emit, emit, line_end, last_row, last_pad, start_frame;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            pad_q    <= '0;
            credit_q <= CREDIT_MAX;
            data_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            pad_q    <= pad_d;
            credit_q <= credit_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (i_start) state_d = SEND;
            SEND: if (line_end && last_row) state_d = (PAD_LINES > 0) ? PAD : DONE;
            PAD:  if (line_end && last_pad) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Credit is only tested at emit time; it is consumed at line end, so a started line always finishes.
    always_comb begin
        s_ready     = (state_q == SEND) && (credit_q != '0);
        o_busy      = (state_q == SEND) || (state_q == PAD);
        xfer        = s_valid && s_ready;
        pad_emit    = (state_q == PAD) && (credit_q != '0);
        emit        = xfer || pad_emit;
        line_end    = emit && (col_q == COL_LAST);
        last_row    = (row_q == ROW_LAST);
        last_pad    = (pad_q == PAD_LAST);
        start_frame = (state_q == IDLE) && i_start;
        done_d      = (state_q == DONE);

        data_d  = data_q;
        valid_d = 1'b0;
        if (xfer) begin
            data_d  = s_data;
            valid_d = 1'b1;
        end else if (pad_emit) begin
            data_d  = '0;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        pad_d    = pad_q;
        credit_d = credit_q;
        err_d    = err_q;

        if (start_frame) begin
            col_d = '0;
            row_d = '0;
            pad_d = '0;
        end else if (emit) begin
            col_d = line_end ? '0 : col_q + 1'b1;
            if (line_end && state_q == SEND) row_d = last_row ? '0 : row_q + 1'b1;
            if (line_end && state_q == PAD)  pad_d = last_pad ? '0 : pad_q + 1'b1;
        end

        unique case ({i_intr, line_end})
            2'b10:   if (credit_q != CREDIT_MAX) credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase

        if (xfer && (s_last != (last_row && col_q == COL_LAST))) err_d = 1'b1;
        if (i_intr && !line_end && credit_q == CREDIT_MAX)       err_d = 1'b1;
    end

    assign o_pixel_data       = data_q;
    assign o_pixel_data_valid = valid_q;
    assign o_frame_done       = done_q;
    assign o_err              = err_q;

endmodule

// File: tb/tb_line_feed_control.sv
// Bench for line_feed_control: a small 8x4 instance for framing/padding/credit corners and a
// default 640x480 instance for full-width line credit and mid-line reset.
module tb_line_feed_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sm_rst = 1'b1, sm_start = 1'b0, sm_valid = 1'b0, sm_last = 1'b0, sm_intr = 1'b0;
    logic [7:0] sm_data = '0;
    logic       sm_ready, sm_ovalid, sm_done, sm_err, sm_busy;
    logic [7:0] sm_odata;

    logic       bg_rst = 1'b1, bg_start = 1'b0, bg_valid = 1'b0, bg_last = 1'b0, bg_intr = 1'b0;
    logic [7:0] bg_data = '0;
    logic       bg_ready, bg_ovalid, bg_done, bg_err, bg_busy;
    logic [7:0] bg_odata;

    line_feed_control #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .NUM_LINEBUF(4), .PAD_LINES(2)) u_small (
        .i_clk(clk), .i_rst(sm_rst), .i_start(sm_start), .s_data(sm_data), .s_valid(sm_valid),
        .s_last(sm_last), .s_ready(sm_ready), .o_pixel_data(sm_odata),
        .o_pixel_data_valid(sm_ovalid), .i_intr(sm_intr), .o_frame_done(sm_done),
        .o_err(sm_err), .o_busy(sm_busy)
    );

    line_feed_control u_big (
        .i_clk(clk), .i_rst(bg_rst), .i_start(bg_start), .s_data(bg_data), .s_valid(bg_valid),
        .s_last(bg_last), .s_ready(bg_ready), .o_pixel_data(bg_odata),
        .o_pixel_data_valid(bg_ovalid), .i_intr(bg_intr), .o_frame_done(bg_done),
        .o_err(bg_err), .o_busy(bg_busy)
    );

    typedef struct {
        logic       rst, start, valid, last, intr;
        logic [7:0] data;
        logic       exp_rdy, exp_val;
        logic [7:0] exp_dat;
        logic       exp_done, exp_err, exp_busy;
    } vec_t;

    int n_vec = 0, n_err = 0;
    int cyc = 0, out_cnt = 0, pad_bad = 0, done_cnt = 0, done_cyc = 0, last_out_cyc = 0;
    bit auto_intr = 1'b0;
    int bidx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; samples the small instance's outputs and, when enabled, returns a credit
    // on the cycle after every line it emits.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sm_intr = 1'b0;
        if (sm_ovalid) begin
            out_cnt++;
            last_out_cyc = cyc;
            if (out_cnt > 32 && sm_odata != 8'h00) pad_bad++;
        end
        if (sm_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (auto_intr && sm_ovalid && (out_cnt % 8 == 0)) sm_intr = 1'b1;
    endtask

    task automatic clear_counts();
        out_cnt = 0; pad_bad = 0; done_cnt = 0; done_cyc = 0; last_out_cyc = 0;
    endtask

    task automatic small_reset();
        sm_rst = 1'b1; tick(); sm_rst = 1'b0; clear_counts();
    endtask

    task automatic small_start();
        sm_start = 1'b1; tick(); sm_start = 1'b0;
    endtask

    task automatic stream_small(input int bad_last, input int intr_at);
        for (int k = 0; k < 32; k++) begin
            int w;
            sm_valid = 1'b1;
            sm_data  = 8'(k + 1);
            sm_last  = (k == 31) || (k == bad_last);
            w = 0;
            while (!sm_ready && w < 50) begin tick(); w++; end
            check($sformatf("sm_ready_px%0d", k), 32'(sm_ready), 32'd1);
            if (k == intr_at) sm_intr = 1'b1;
            tick();
            check($sformatf("sm_out_px%0d", k), {sm_ovalid, sm_odata}, {1'b1, 8'(k + 1)});
            if (k == bad_last - 1) check("sm_err_before_bad_last", 32'(sm_err), 32'd0);
            if (k == bad_last)     check("sm_err_after_bad_last", 32'(sm_err), 32'd1);
        end
        sm_valid = 1'b0;
        sm_last  = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic stream_big(input int n, input int budget, output int acc, output int used);
        logic       was;
        logic [7:0] exp;
        acc = 0;
        used = 0;
        while (acc < n && used < budget) begin
            bg_valid = 1'b1;
            bg_data  = 8'(bidx) ^ 8'h5A;
            was      = bg_ready;
            exp      = bg_data;
            tick();
            used++;
            if (was) begin
                check("big_out", {bg_ovalid, bg_odata}, {1'b1, exp});
                acc++;
                bidx++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[9];
        int   acc, used;

        tbl[0] = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0};
        tbl[1] = '{0, 0, 1, 0, 0, 8'hAA, 0, 0, 8'h00, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1};
        tbl[3] = '{0, 0, 1, 0, 0, 8'h11, 1, 1, 8'h11, 0, 0, 1};
        tbl[4] = '{0, 0, 0, 0, 0, 8'h00, 1, 0, 8'h11, 0, 0, 1};
        tbl[5] = '{0, 1, 1, 0, 0, 8'h22, 1, 1, 8'h22, 0, 0, 1};
        tbl[6] = '{0, 0, 0, 0, 1, 8'h00, 1, 0, 8'h22, 0, 1, 1};
        tbl[7] = '{1, 0, 1, 0, 0, 8'h33, 1, 0, 8'h00, 0, 0, 0};
        tbl[8] = '{0, 0, 1, 0, 0, 8'h44, 0, 0, 8'h00, 0, 0, 0};

        tick(); tick();
        sm_rst = 1'b0;
        bg_rst = 1'b0;
        check("big_reset_state", {bg_ready, bg_ovalid, bg_odata, bg_done, bg_err, bg_busy}, 32'd0);

        // Directed vectors: idle rejection, start, latency, ignored restart, overflow, reset mid-line
        for (int i = 0; i < 9; i++) begin
            sm_rst = tbl[i].rst; sm_start = tbl[i].start; sm_valid = tbl[i].valid;
            sm_last = tbl[i].last; sm_intr = tbl[i].intr; sm_data = tbl[i].data;
            check($sformatf("vec%0d_ready", i), 32'(sm_ready), 32'(tbl[i].exp_rdy));
            tick();
            check($sformatf("vec%0d_out", i), {sm_ovalid, sm_odata, sm_done, sm_err, sm_busy},
                  {tbl[i].exp_val, tbl[i].exp_dat, tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_busy});
        end
        sm_rst = 1'b0; sm_start = 1'b0; sm_valid = 1'b0; sm_intr = 1'b0;

        // Full small frame with a credit returned after every line: 32 pixels + 16 pad zeros
        small_reset();
        auto_intr = 1'b1;
        small_start();
        stream_small(-1, -1);
        drain(40);
        check("frame_out_count", 32'(out_cnt), 32'd48);
        check("frame_pad_nonzero", 32'(pad_bad), 32'd0);
        check("frame_done_count", 32'(done_cnt), 32'd1);
        check("frame_done_timing", 32'(done_cyc), 32'(last_out_cyc + 1));
        check("frame_err", 32'(sm_err), 32'd0);
        check("frame_busy_end", 32'(sm_busy), 32'd0);

        // Credit returned on the same cycle as a line end leaves credit at 4
        small_reset();
        auto_intr = 1'b0;
        small_start();
        stream_small(-1, 7);
        drain(30);
        check("coinc_out_before_stall", 32'(out_cnt), 32'd40);
        check("coinc_stalled_busy", {sm_busy, sm_done, sm_ovalid}, 3'b100);
        check("coinc_no_done", 32'(done_cnt), 32'd0);
        sm_intr = 1'b1;
        tick();
        drain(20);
        check("coinc_out_total", 32'(out_cnt), 32'd48);
        check("coinc_done", 32'(done_cnt), 32'd1);
        check("coinc_err", 32'(sm_err), 32'd0);

        // Refill credit 0 -> 4 without error, then one more return overflows
        for (int i = 0; i < 4; i++) begin sm_intr = 1'b1; tick(); end
        check("refill_no_err", 32'(sm_err), 32'd0);
        sm_intr = 1'b1;
        tick();
        check("overflow_err", 32'(sm_err), 32'd1);
        clear_counts();
        small_start();
        stream_small(-1, -1);
        drain(20);
        check("saturated_credit_lines", 32'(out_cnt), 32'd32);
        check("saturated_busy", 32'(sm_busy), 32'd1);
        check("err_sticky", 32'(sm_err), 32'd1);

        // Misplaced s_last at row 0 col 5: error flagged, frame still completes
        small_reset();
        auto_intr = 1'b1;
        small_start();
        stream_small(5, -1);
        drain(40);
        check("badlast_out_total", 32'(out_cnt), 32'd48);
        check("badlast_done", 32'(done_cnt), 32'd1);
        check("badlast_err", 32'(sm_err), 32'd1);
        auto_intr = 1'b0;

        // Default size: four full lines use all credit
        bg_start = 1'b1; tick(); bg_start = 1'b0;
        stream_big(2560, 2700, acc, used);
        check("big_4lines_acc", 32'(acc), 32'd2560);
        check("big_4lines_continuous", 32'(used), 32'd2560);
        check("big_ready_drop", 32'(bg_ready), 32'd0);
        tick();
        check("big_stalled", {bg_ready, bg_ovalid, bg_busy}, 3'b001);

        // One credit back -> exactly one more line
        bg_intr = 1'b1; tick(); bg_intr = 1'b0;
        check("big_ready_return", 32'(bg_ready), 32'd1);
        stream_big(1000, 700, acc, used);
        check("big_one_line_acc", 32'(acc), 32'd640);
        check("big_ready_low_again", 32'(bg_ready), 32'd0);

        // Reset mid-line at col 300, then restart from row 0 col 0 with full credit
        bg_intr = 1'b1; tick(); bg_intr = 1'b0;
        stream_big(300, 310, acc, used);
        check("big_partial_acc", 32'(acc), 32'd300);
        bg_rst = 1'b1; bg_valid = 1'b1; bg_data = 8'hC3;
        tick();
        bg_rst = 1'b0;
        check("big_midreset", {bg_ready, bg_ovalid, bg_odata, bg_busy, bg_err, bg_done}, 32'd0);
        tick();
        check("big_idle_after_reset", {bg_ready, bg_ovalid, bg_busy}, 3'b000);
        bg_valid = 1'b0;
        bg_start = 1'b1; tick(); bg_start = 1'b0;
        stream_big(2560, 2700, acc, used);
        check("big_restart_acc", 32'(acc), 32'd2560);
        check("big_restart_continuous", 32'(used), 32'd2560);
        check("big_restart_ready_drop", 32'(bg_ready), 32'd0);
        check("big_restart_err", 32'(bg_err), 32'd0);
        bg_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_feed_control.md
Name: line_feed_control

Overview:
- Source-side feeder for the 4-line-buffer window generator.
- Accepts an 8-bit pixel stream from the DMA/AXI-Stream side and forwards it as the pixel_data/pixel_data_valid pair the window generator consumes.
- Line-credit flow control driven by the generator's per-line interrupt prevents overwriting an unread line buffer.
- Appends zero padding lines at end of frame so the last image rows are drained through the 3x3 window.

Parameters:
- IMG_WIDTH, 640, pixels per line.
- IMG_HEIGHT, 480, image lines per frame.
- NUM_LINEBUF, 4, line buffers in the downstream generator; initial and maximum credit count.
- PAD_LINES, 2, zero lines appended after the last image line; 0 disables padding.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle pulse; starts a frame, honoured only in IDLE.
- s_data  in  8  input pixel.
- s_valid  in  1  input pixel valid.
- s_last  in  1  input end-of-frame marker.
- s_ready  out  1  feeder accepts s_data this cycle.
- o_pixel_data  out  8  pixel to the window generator.
- o_pixel_data_valid  out  1  o_pixel_data valid.
- i_intr  in  1  one-cycle pulse from the generator: one line buffer freed.
- o_frame_done  out  1  one-cycle pulse when the frame and its padding are fully sent.
- o_err  out  1  sticky: s_last misplaced, or credit overflow.
- o_busy  out  1  high in SEND or PAD.

Behaviour:
- Reset values: o_pixel_data 0, o_pixel_data_valid 0, o_frame_done 0, o_err 0, s_ready 0, state IDLE, col 0, row 0, pad count 0, credit NUM_LINEBUF.
- Reset asserted mid-frame: all of the above restored the next cycle; no partial line is completed.
- Counter widths: col is $clog2(IMG_WIDTH) bits; row is $clog2(IMG_HEIGHT) bits; credit is $clog2(NUM_LINEBUF+1) bits.
- s_ready is combinational: s_ready = (state==SEND) && (credit!=0).
- Transfer occurs when s_valid && s_ready.
- Output registered, 1-cycle latency: on a transfer, o_pixel_data <= s_data and o_pixel_data_valid <= 1; otherwise o_pixel_data_valid <= 0 except in PAD.
- Columns: col advances per emitted pixel and wraps IMG_WIDTH-1 -> 0.
- Line end is the emit with col==IMG_WIDTH-1. At line end, row or pad count increments and credit decrements.
- Credit is checked only at line start and reserved for the whole line: since decrement occurs only at line end, credit>=1 holds throughout a line in progress.
- Credit update:
  - i_intr alone: +1.
  - Line end alone: -1.
  - Both in the same cycle: unchanged.
  - i_intr while credit==NUM_LINEBUF: credit stays saturated and o_err is set.
- States:
  - IDLE: i_start -> SEND; col, row and pad count cleared. Credit is not reset, because it tracks the generator across frames.
  - SEND: accept pixels. Line end with row==IMG_HEIGHT-1 -> PAD if PAD_LINES>0, else DONE.
  - PAD: s_ready=0. Emits o_pixel_data=0 with valid=1 every cycle credit!=0 and stalls while credit==0. Line end with pad count==PAD_LINES-1 -> DONE.
  - DONE: o_frame_done=1 for exactly one cycle -> IDLE.
- s_last: on a transfer, s_last must equal (row==IMG_HEIGHT-1 && col==IMG_WIDTH-1). Any mismatch sets o_err; the frame continues on internal counts.
- o_err clears only on i_rst.
- i_start outside IDLE is ignored.
- s_valid in IDLE or PAD is not accepted (s_ready=0).
- o_busy = (state==SEND || state==PAD).

Test Plan:
- Defaults; i_start; 4 lines streamed continuously with no i_intr -> 2560 accepted pixels, each output 1 cycle after its input. s_ready drops the cycle after the 2560th transfer; credit=0.
- Continue from the previous scenario: pulse i_intr once -> s_ready returns next cycle; exactly 640 more pixels accepted, then s_ready low again.
- IMG_WIDTH=8, IMG_HEIGHT=4, PAD_LINES=2, i_intr pulsed after every line -> 32 image pixels, then 16 zero-valued valid outputs. o_frame_done pulses once after the 48th output; o_err=0.
- i_intr coincident with a line-end transfer -> credit unchanged. i_intr with credit at 4 -> credit stays 4 and o_err=1.
- s_last asserted on pixel (row 0, col 5) -> o_err=1; frame still completes on counts with o_frame_done.
- i_rst mid-line at col 300 -> next cycle s_ready=0, o_pixel_data_valid=0, credit=4, state IDLE. A new i_start restarts at row 0, col 0.
